svnet_ram_arbiter: RTL and testbench

- Shares one svnet_ram instance between CLIENTS requesters, each with its own write port and read port.
- Independent round-robin arbitration on the write channel and the read channel.
- Enforces the RAM's minimum write-to-write and read-to-read issue spacing.
- Tags every issued read and returns its data only to the client that issued it.
- Sits between the layer engines and a shared weight/feature RAM.

---
 rtl/svnet_ram_arbiter_pkg.sv | 42 ++++
 rtl/svnet_rr_arbiter.sv | 59 +++++
 rtl/svnet_ram_arbiter.sv | 94 +++++++++
 tb/tb_svnet_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svnet_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// svnet_ram_arbiter_pkg: shared tag type and round-robin pick helper.
// Revision: 1.0
// ============================================================================
package svnet_ram_arbiter_pkg;

  localparam int unsigned c_rr_max_clients = 64;
  localparam int unsigned c_rr_idx_w       = 6;

  typedef struct packed {
    logic                  valid;
    logic [c_rr_idx_w-1:0] index;
  } tag_t;

  typedef struct packed {
    logic                  found;
    logic [c_rr_idx_w-1:0] index;
  } pick_t;

  // First asserted req at or after ptr, scanning upward modulo n.
  function automatic pick_t rr_pick(input logic [c_rr_max_clients-1:0] req,
                                    input logic [c_rr_idx_w-1:0]       ptr,
                                    input int unsigned                 n);
    pick_t       pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned i = 0; i < c_rr_max_clients; i++) begin
      if (i < n) begin
        idx = {26'd0, ptr} + i;
        if (idx >= n) idx = idx - n;
        if (!pick.found && req[idx[c_rr_idx_w-1:0]]) begin
          pick.found = 1'b1;
          pick.index = idx[c_rr_idx_w-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/svnet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// svnet_rr_arbiter: round-robin grant with minimum issue spacing.
// Revision: 1.0
// ============================================================================
module svnet_rr_arbiter
  import svnet_ram_arbiter_pkg::*;
#(
  parameter int unsigned  CLIENTS = 2,
  parameter int unsigned  DELAY   = 2,
  localparam int unsigned c_cw    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLIENTS-1:0] req,
  output logic [CLIENTS-1:0] grant,
  output logic               issue,
  output logic [c_cw-1:0]    index
);

  localparam int unsigned c_dw = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [c_cw-1:0]       r_ptr;
  logic [c_dw-1:0]       r_cnt;
  pick_t                 w_pick;
  logic [c_rr_idx_w:0]   w_next;

  always_comb begin
    w_pick = rr_pick(c_rr_max_clients'(req), c_rr_idx_w'(r_ptr), CLIENTS);
    w_next = {1'b0, w_pick.index} + (c_rr_idx_w + 1)'(1);
    if (w_next >= (c_rr_idx_w + 1)'(CLIENTS)) w_next = '0;
    issue = !rst && (r_cnt == '0) && w_pick.found;
    index = c_cw'(w_pick.index);
    grant = issue ? (CLIENTS'(1) << w_pick.index) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (issue) begin
      r_ptr <= c_cw'(w_next);
      r_cnt <= c_dw'(DELAY - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_dw'(1);
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_req:    assert property (@(posedge clk) disable iff (rst) (grant & ~req) == '0);

  generate
    for (genvar k = 1; k < DELAY; k++) begin : g_spacing
      a_spacing: assert property (@(posedge clk) disable iff (rst) issue |-> !$past(issue, k));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/svnet_ram_arbiter.sv
`default_nettype none
// ============================================================================
// svnet_ram_arbiter: shares one svnet_ram between CLIENTS read/write ports.
// Revision: 1.0
// ============================================================================
module svnet_ram_arbiter
  import svnet_ram_arbiter_pkg::*;
#(
  parameter int unsigned  CLIENTS      = 2,
  parameter int unsigned  DEPTH        = 1,
  parameter int unsigned  WIDTH        = 1,
  parameter int unsigned  W2W_DELAY    = 2,
  parameter int unsigned  R2R_DELAY    = 2,
  parameter int unsigned  READ_LATENCY = 2,
  localparam int unsigned c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CLIENTS-1:0]                req_write,
  input  logic [CLIENTS-1:0][c_aw-1:0]      req_write_address,
  input  logic [CLIENTS-1:0][WIDTH-1:0]     req_write_data,
  output logic [CLIENTS-1:0]                write_grant,
  input  logic [CLIENTS-1:0]                req_read,
  input  logic [CLIENTS-1:0][c_aw-1:0]      req_read_address,
  output logic [CLIENTS-1:0]                read_grant,
  output logic [CLIENTS-1:0]                rsp_valid,
  output logic [WIDTH-1:0]                  rsp_data,
  output logic                              ram_write,
  output logic [c_aw-1:0]                   ram_write_address,
  output logic [WIDTH-1:0]                  ram_write_data,
  output logic                              ram_read,
  output logic [c_aw-1:0]                   ram_read_address,
  input  logic                              ram_read_data_valid,
  input  logic [WIDTH-1:0]                  ram_read_data
);

  localparam int unsigned c_cw = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  logic            w_wr_issue;
  logic            w_rd_issue;
  logic [c_cw-1:0] w_wr_index;
  logic [c_cw-1:0] w_rd_index;
  tag_t            r_tag [READ_LATENCY];
  tag_t            w_tag_out;

  svnet_rr_arbiter #(.CLIENTS(CLIENTS), .DELAY(W2W_DELAY)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_write),
    .grant (write_grant),
    .issue (w_wr_issue),
    .index (w_wr_index)
  );

  svnet_rr_arbiter #(.CLIENTS(CLIENTS), .DELAY(R2R_DELAY)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_read),
    .grant (read_grant),
    .issue (w_rd_issue),
    .index (w_rd_index)
  );

  assign ram_write         = w_wr_issue;
  assign ram_write_address = req_write_address[w_wr_index];
  assign ram_write_data    = req_write_data[w_wr_index];
  assign ram_read          = w_rd_issue;
  assign ram_read_address  = req_read_address[w_rd_index];

  // Tags travel alongside the RAM's read latency so data finds its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_rd_issue, index: c_rr_idx_w'(w_rd_index)};
      for (int i = 1; i < int'(READ_LATENCY); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out = r_tag[READ_LATENCY-1];
  assign rsp_data  = ram_read_data;

  generate
    for (genvar i = 0; i < CLIENTS; i++) begin : g_rsp
      assign rsp_valid[i] = ram_read_data_valid && w_tag_out.valid &&
                            (w_tag_out.index == c_rr_idx_w'(i));
    end
  endgenerate

  a_tag_align: assert property (@(posedge clk) disable iff (rst)
                                ram_read_data_valid == w_tag_out.valid);

endmodule
`default_nettype wire

// File: tb/tb_svnet_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for svnet_ram_arbiter: vector table, directed corner cases and a
// randomized run checked against a cycle-level reference of the arbitration rules.
module tb_svnet_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: CLIENTS=2, DEPTH=16, WIDTH=8, delays 2, latency 2.
  logic [1:0]       req_write, req_read, write_grant, read_grant, rsp_valid;
  logic [1:0][3:0]  req_write_address, req_read_address;
  logic [1:0][7:0]  req_write_data;
  logic [7:0]       rsp_data, ram_write_data, ram_read_data;
  logic [3:0]       ram_write_address, ram_read_address;
  logic             ram_write, ram_read, ram_read_data_valid;

  svnet_ram_arbiter #(.CLIENTS(2), .DEPTH(16), .WIDTH(8), .W2W_DELAY(2),
                      .R2R_DELAY(2), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_write(req_write), .req_write_address(req_write_address),
    .req_write_data(req_write_data), .write_grant(write_grant),
    .req_read(req_read), .req_read_address(req_read_address),
    .read_grant(read_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write(ram_write), .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data), .ram_read(ram_read),
    .ram_read_address(ram_read_address),
    .ram_read_data_valid(ram_read_data_valid), .ram_read_data(ram_read_data)
  );

  // RAM model: registered inputs, two-cycle read latency, read-before-write.
  logic [7:0] mem [16];
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  always @(posedge clk) begin
    v0 <= ram_read;
    d0 <= mem[ram_read_address];
    v1 <= v0;
    d1 <= d0;
    if (ram_write) mem[ram_write_address] <= ram_write_data;
  end
  assign ram_read_data_valid = v1;
  assign ram_read_data       = d1;

  // Second instance: CLIENTS=3, W2W_DELAY=1, write channel only.
  logic [2:0]      req_write_c3, write_grant_c3, read_grant_c3, rsp_valid_c3;
  logic [2:0][3:0] req_addr_c3;
  logic [2:0][7:0] req_data_c3;
  logic [7:0]      rsp_data_c3, ram_wdata_c3;
  logic [3:0]      ram_waddr_c3, ram_raddr_c3;
  logic            ram_write_c3, ram_read_c3;

  svnet_ram_arbiter #(.CLIENTS(3), .DEPTH(16), .WIDTH(8), .W2W_DELAY(1),
                      .R2R_DELAY(2), .READ_LATENCY(2)) dut_c3 (
    .clk(clk), .rst(rst),
    .req_write(req_write_c3), .req_write_address(req_addr_c3),
    .req_write_data(req_data_c3), .write_grant(write_grant_c3),
    .req_read(3'b000), .req_read_address(req_addr_c3),
    .read_grant(read_grant_c3), .rsp_valid(rsp_valid_c3), .rsp_data(rsp_data_c3),
    .ram_write(ram_write_c3), .ram_write_address(ram_waddr_c3),
    .ram_write_data(ram_wdata_c3), .ram_read(ram_read_c3),
    .ram_read_address(ram_raddr_c3),
    .ram_read_data_valid(1'b0), .ram_read_data(8'h00)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    req_write = '0; req_read = '0;
    req_write_address = '0; req_read_address = '0; req_write_data = '0;
    req_write_c3 = '0; req_addr_c3 = '0; req_data_c3 = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] rw, rr, wg, rg, rv;
  } vec_t;
  vec_t tbl [9];

  typedef struct {
    int         due;
    int         client;
    logic [7:0] data;
  } rsp_t;
  rsp_t       q [$];
  bit         pw [2], pr [2];
  logic [3:0] wa [2], ra [2];
  logic [7:0] wd [2];
  logic [7:0] rmem [16];
  int         wptr, rptr, wlast, rlast, ewc, erc, exp_rv, cc;
  logic [7:0] exp_rd;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    clear_reqs();

    // Two-client grant pattern from a fresh reset (write and read pointers at 0).
    tbl[0] = '{rw: 2'b11, rr: 2'b10, wg: 2'b01, rg: 2'b10, rv: 2'b00};
    tbl[1] = '{rw: 2'b10, rr: 2'b01, wg: 2'b00, rg: 2'b00, rv: 2'b00};
    tbl[2] = '{rw: 2'b10, rr: 2'b01, wg: 2'b10, rg: 2'b01, rv: 2'b10};
    tbl[3] = '{rw: 2'b01, rr: 2'b11, wg: 2'b00, rg: 2'b00, rv: 2'b00};
    tbl[4] = '{rw: 2'b01, rr: 2'b11, wg: 2'b01, rg: 2'b10, rv: 2'b01};
    tbl[5] = '{rw: 2'b00, rr: 2'b01, wg: 2'b00, rg: 2'b00, rv: 2'b00};
    tbl[6] = '{rw: 2'b11, rr: 2'b01, wg: 2'b10, rg: 2'b01, rv: 2'b10};
    tbl[7] = '{rw: 2'b00, rr: 2'b00, wg: 2'b00, rg: 2'b00, rv: 2'b00};
    tbl[8] = '{rw: 2'b00, rr: 2'b00, wg: 2'b00, rg: 2'b00, rv: 2'b01};

    // Reset state.
    @(negedge clk);
    chk("reset_write_grant", write_grant, 2'b00);
    chk("reset_read_grant", read_grant, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_ram_write", ram_write, 1'b0);
    chk("reset_ram_read", ram_read, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", rsp_valid, 2'b00);
    chk("post_reset_write_grant", write_grant, 2'b00);
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) begin
      req_write = tbl[k].rw;
      req_read  = tbl[k].rr;
      @(negedge clk);
      chk("tbl_write_grant", write_grant, tbl[k].wg);
      chk("tbl_read_grant", read_grant, tbl[k].rg);
      chk("tbl_rsp_valid", rsp_valid, tbl[k].rv);
      chk("tbl_ram_write", ram_write, |tbl[k].wg);
      chk("tbl_ram_read", ram_read, |tbl[k].rg);
      @(posedge clk); #1;
    end

    // Write 0xA5 to address 3, read it back four cycles later.
    do_reset();
    for (int j = 0; j <= 7; j++) begin
      req_write = (j == 0) ? 2'b01 : 2'b00;
      req_write_address[0] = 4'd3; req_write_data[0] = 8'hA5;
      req_read = (j == 4) ? 2'b01 : 2'b00;
      req_read_address[0] = 4'd3;
      @(negedge clk);
      chk("t1_write_grant", write_grant, (j == 0) ? 2'b01 : 2'b00);
      if (j == 0) begin
        chk("t1_ram_write_address", ram_write_address, 4'd3);
        chk("t1_ram_write_data", ram_write_data, 8'hA5);
      end
      chk("t1_read_grant", read_grant, (j == 4) ? 2'b01 : 2'b00);
      chk("t1_rsp_valid", rsp_valid, (j == 6) ? 2'b01 : 2'b00);
      if (j == 6) chk("t1_rsp_data", rsp_data, 8'hA5);
      @(posedge clk); #1;
    end

    // Both clients hold req_read: grants alternate every other cycle.
    do_reset();
    for (int j = 0; j < 10; j++) begin
      req_read = (j < 8) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("alt_read_grant", read_grant,
          (j % 2 == 1 || j >= 8) ? 2'b00 : ((j % 4 == 0) ? 2'b01 : 2'b10));
      chk("alt_rsp_valid", rsp_valid,
          (j % 2 == 1 || j < 2) ? 2'b00 : ((j % 4 == 2) ? 2'b01 : 2'b10));
      @(posedge clk); #1;
    end

    // Same-address hazard: same-cycle read sees old data, later read sees new.
    do_reset();
    for (int j = 0; j <= 6; j++) begin
      clear_reqs();
      req_write_address[0] = 4'd5; req_read_address[0] = 4'd5;
      req_write_data[0] = (j == 0) ? 8'h11 : 8'h22;
      req_write[0] = (j == 0 || j == 2);
      req_read[0]  = (j == 2 || j == 4);
      @(negedge clk);
      if (j == 2) begin
        chk("hz_write_grant", write_grant, 2'b01);
        chk("hz_read_grant", read_grant, 2'b01);
      end
      chk("hz_rsp_valid", rsp_valid, (j == 4 || j == 6) ? 2'b01 : 2'b00);
      if (j == 4) chk("hz_old_data", rsp_data, 8'h11);
      if (j == 6) chk("hz_new_data", rsp_data, 8'h22);
      @(posedge clk); #1;
    end

    // Reset one cycle after a read grant: response suppressed, pointers cleared.
    do_reset();
    for (int j = 0; j <= 6; j++) begin
      clear_reqs();
      rst = (j >= 1 && j <= 3);
      if (j == 0) begin req_write = 2'b01; req_read = 2'b01; end
      if (j == 5) begin req_write = 2'b11; req_read = 2'b11; end
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      if (j == 5) begin
        chk("rst_write_ptr", write_grant, 2'b01);
        chk("rst_read_ptr", read_grant, 2'b01);
      end
      @(posedge clk); #1;
    end

    // Three clients, W2W_DELAY=1: back-to-back rotation.
    do_reset();
    req_write_c3 = 3'b111;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("c3_write_grant", write_grant_c3, 32'd1 << (j % 3));
      chk("c3_ram_write", ram_write_c3, 1'b1);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 16; i++) rmem[i] = mem[i];
    wptr = 0; rptr = 0; wlast = -100; rlast = -100;
    for (int c = 0; c < 2; c++) begin
      pw[c] = 0; pr[c] = 0; wa[c] = '0; ra[c] = '0; wd[c] = '0;
    end
    for (int t = 0; t < 404; t++) begin
      for (int c = 0; c < 2; c++) begin
        if (t >= 400) begin
          pw[c] = 0; pr[c] = 0;
        end else begin
          if (!pw[c] && $urandom_range(0, 2) == 0) begin
            pw[c] = 1; wa[c] = 4'($urandom_range(0, 15)); wd[c] = 8'($urandom_range(0, 255));
          end else if (pw[c] && $urandom_range(0, 19) == 0) pw[c] = 0;
          if (!pr[c] && $urandom_range(0, 2) == 0) begin
            pr[c] = 1; ra[c] = 4'($urandom_range(0, 15));
          end else if (pr[c] && $urandom_range(0, 19) == 0) pr[c] = 0;
        end
        req_write[c] = pw[c]; req_write_address[c] = wa[c]; req_write_data[c] = wd[c];
        req_read[c]  = pr[c]; req_read_address[c]  = ra[c];
      end
      ewc = -1; erc = -1;
      for (int k = 0; k < 2; k++) begin
        cc = (wptr + k) % 2;
        if (t - wlast >= 2 && ewc < 0 && pw[cc]) ewc = cc;
        cc = (rptr + k) % 2;
        if (t - rlast >= 2 && erc < 0 && pr[cc]) erc = cc;
      end
      exp_rv = 0; exp_rd = '0;
      if (q.size() > 0 && q[0].due == t) begin
        exp_rv = 1 << q[0].client; exp_rd = q[0].data;
        void'(q.pop_front());
      end
      @(negedge clk);
      chk("rnd_write_grant", write_grant, (ewc < 0) ? 0 : (1 << ewc));
      chk("rnd_read_grant", read_grant, (erc < 0) ? 0 : (1 << erc));
      if (ewc >= 0) begin
        chk("rnd_ram_write_address", ram_write_address, wa[ewc]);
        chk("rnd_ram_write_data", ram_write_data, wd[ewc]);
      end
      if (erc >= 0) chk("rnd_ram_read_address", ram_read_address, ra[erc]);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 0) chk("rnd_rsp_data", rsp_data, exp_rd);
      if (erc >= 0) begin
        q.push_back('{t + 2, erc, rmem[ra[erc]]});
        rptr = (erc + 1) % 2; rlast = t; pr[erc] = 0;
      end
      if (ewc >= 0) begin
        rmem[wa[ewc]] = wd[ewc];
        wptr = (ewc + 1) % 2; wlast = t; pw[ewc] = 0;
      end
      @(posedge clk); #1;
    end
    chk("rnd_rsp_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
